// File: rtl/quant_pkg.sv
// Shared definitions for the VSQ quantize controller and the quantize engine.
// Holds the tile geometry, the default tile-count width and the FSM encoding.
package quant_pkg;

  localparam int Q_ROWS = 64;
  localparam int Q_TW   = 8;
  localparam int Q_AW   = $clog2(Q_ROWS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_KICK,
    ST_DRAIN,
    ST_DONE
  } q_state_e;

endpackage

// File: rtl/quant_cnt_mod.sv
// Modulo up-counter shared by the row-fill and drain sequencing.
// Holds at 0 while cleared; rolls over to 0 after MAX.
module quant_cnt_mod #(
  parameter int W   = 6,
  parameter int MAX = 63
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      if (o_cnt == W'(MAX))
        o_cnt <= '0;
      else
        o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quant_ctrl.sv
// Job sequencer for VSQ quantization: fills one tile of rows into the buffer,
// kicks the quantize engine, waits for its output rows, repeats per tile.
module quant_ctrl
  import quant_pkg::*;
#(
  parameter int ROWS = Q_ROWS,
  parameter int TW   = Q_TW
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cfg_valid,
  input  logic [TW-1:0]   i_cfg_tiles,
  output logic            o_cfg_ready,
  input  logic            i_row_valid,
  output logic            o_row_ready,
  output logic            o_row_fire,
  output logic            o_buf_we,
  output logic [Q_AW-1:0] o_buf_waddr,
  output logic            o_q_start,
  input  logic            i_q_ram_we,
  output logic            o_busy,
  output logic            o_done,
  output logic [TW-1:0]   o_tile_cnt,
  output logic            o_err
);

  localparam int CW = $clog2(ROWS);

  q_state_e      state;
  logic [TW-1:0] tiles_q;
  logic [CW-1:0] row_cnt;
  logic [CW-1:0] drn_cnt;
  logic          cfg_fire;
  logic          drn_en;
  logic          row_last;
  logic          drn_last;
  logic          stray;

  assign o_cfg_ready = (state == ST_IDLE);
  assign o_row_ready = (state == ST_FILL);
  assign o_row_fire  = i_row_valid && o_row_ready;
  assign o_buf_we    = o_row_fire;
  assign o_buf_waddr = Q_AW'(row_cnt);
  assign o_q_start   = (state == ST_KICK);
  assign o_done      = (state == ST_DONE);
  assign o_busy      = (state != ST_IDLE);

  assign cfg_fire = i_cfg_valid && o_cfg_ready;
  assign drn_en   = i_q_ram_we && (state == ST_DRAIN);
  assign stray    = i_q_ram_we && (state != ST_DRAIN);
  assign row_last = o_row_fire && (row_cnt == CW'(ROWS - 1));
  assign drn_last = drn_en && (drn_cnt == CW'(ROWS - 1));

  // Counters sit at 0 outside their state, so each entry starts fresh.
  quant_cnt_mod #(.W(CW), .MAX(ROWS - 1)) u_row_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state != ST_FILL),
    .i_en    (o_row_fire),
    .o_cnt   (row_cnt)
  );

  quant_cnt_mod #(.W(CW), .MAX(ROWS - 1)) u_drn_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state != ST_DRAIN),
    .i_en    (drn_en),
    .o_cnt   (drn_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      tiles_q    <= '0;
      o_tile_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      if (cfg_fire)
        o_err <= 1'b0;
      if (stray)
        o_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            tiles_q    <= i_cfg_tiles;
            o_tile_cnt <= '0;
            state      <= (i_cfg_tiles != '0) ? ST_FILL : ST_DONE;
          end
        end
        ST_FILL: begin
          if (row_last)
            state <= ST_KICK;
        end
        ST_KICK: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drn_last) begin
            o_tile_cnt <= o_tile_cnt + TW'(1);
            if ((o_tile_cnt + TW'(1)) == tiles_q)
              state <= ST_DONE;
            else
              state <= ST_FILL;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quant_ctrl.sv
// Randomized bench for quant_ctrl with a transaction-level job model.
// The bench plays the upstream row source and the quantize engine.
module tb_quant_ctrl;

  localparam int TW   = 8;
  localparam int ROWS = 64;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cfg_valid = 1'b0;
  logic [TW-1:0] i_cfg_tiles = '0;
  logic          o_cfg_ready;
  logic          i_row_valid = 1'b0;
  logic          o_row_ready;
  logic          o_row_fire;
  logic          o_buf_we;
  logic [5:0]    o_buf_waddr;
  logic          o_q_start;
  logic          i_q_ram_we = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic [TW-1:0] o_tile_cnt;
  logic          o_err;

  quant_ctrl #(.ROWS(ROWS), .TW(TW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_valid (i_cfg_valid),
    .i_cfg_tiles (i_cfg_tiles),
    .o_cfg_ready (o_cfg_ready),
    .i_row_valid (i_row_valid),
    .o_row_ready (o_row_ready),
    .o_row_fire  (o_row_fire),
    .o_buf_we    (o_buf_we),
    .o_buf_waddr (o_buf_waddr),
    .o_q_start   (o_q_start),
    .i_q_ram_we  (i_q_ram_we),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_tile_cnt  (o_tile_cnt),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_chk  = 0;

  int cyc = 0;
  int wr_cnt = 0;
  int starts = 0;
  int dones = 0;
  int pend = 0;
  int last_wr_cyc = 0;
  int last_stb_cyc = 0;
  int cfg_cyc = 0;
  int cur_tiles = 0;
  bit cont = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Job model: every write lands at (writes so far) mod ROWS, each tile's
  // start follows its last row, and each tile needs ROWS engine strobes.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (o_buf_we || o_row_fire)
        chk("we_fire", o_buf_we, o_row_fire);
      if (i_row_valid && (pend > 0 || !o_busy))
        chk("row_blocked", o_row_ready, 0);
      if (i_cfg_valid && o_busy)
        chk("cfg_ign", o_cfg_ready, 0);
      if (i_cfg_valid && o_cfg_ready)
        cfg_cyc = cyc;
      if (o_buf_we) begin
        chk("waddr", o_buf_waddr, wr_cnt % ROWS);
        if (cont && wr_cnt > 0 && wr_cnt % ROWS == 0)
          chk("fill_lat", cyc - last_stb_cyc, 1);
        last_wr_cyc = cyc;
        wr_cnt++;
      end
      if (i_q_ram_we)
        last_stb_cyc = cyc;
      if (o_q_start) begin
        chk("start_lat", cyc - last_wr_cyc, 1);
        starts++;
        pend += ROWS;
      end
      if (o_done) begin
        if (cur_tiles == 0)
          chk("done0_lat", cyc - cfg_cyc, 1);
        else
          chk("done_lat", cyc - last_stb_cyc, 1);
        dones++;
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!o_cfg_ready && t < 100) begin
      step();
      t++;
    end
    if (!o_cfg_ready)
      chk("idle_timeout", 0, 1);
  endtask

  task automatic start_job(input int tiles, input int mode);
    wait_idle();
    wr_cnt = 0;
    starts = 0;
    dones = 0;
    pend = 0;
    cur_tiles = tiles;
    cont = (mode == 0);
    i_cfg_valid = 1'b1;
    i_cfg_tiles = TW'(tiles);
    step();
    i_cfg_valid = 1'b0;
    chk("err_clr", o_err, 0);
  endtask

  // mode 0: rows every cycle, 1: rows toggle, 2: random rows and strobes.
  task automatic run_job(input int tiles, input int mode, input bit stray,
                         input bit poke);
    int t = 0;
    bit stray_done = 1'b0;
    bit poked = 1'b0;
    int limit = tiles * 300 + 50;
    start_job(tiles, mode);
    while (dones == 0 && t < limit) begin
      case (mode)
        0: i_row_valid = 1'b1;
        1: i_row_valid = ~i_row_valid;
        default: i_row_valid = 1'($urandom_range(0, 1));
      endcase
      i_cfg_valid = 1'b0;
      if (pend > 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
        i_q_ram_we = 1'b1;
        pend--;
      end else if (stray && !stray_done && pend == 0 &&
                   wr_cnt % ROWS >= 5 && wr_cnt % ROWS <= 60) begin
        i_q_ram_we = 1'b1;
        stray_done = 1'b1;
      end else begin
        i_q_ram_we = 1'b0;
      end
      if (poke && !poked && pend > 0 && pend < 40) begin
        i_cfg_valid = 1'b1;
        i_cfg_tiles = TW'($urandom_range(1, 200));
        poked = 1'b1;
      end
      step();
      t++;
    end
    i_row_valid = 1'b0;
    i_q_ram_we = 1'b0;
    i_cfg_valid = 1'b0;
    if (dones == 0)
      chk("job_timeout", 0, 1);
    chk("writes", wr_cnt, tiles * ROWS);
    chk("starts", starts, tiles);
    chk("tile_cnt", o_tile_cnt, tiles);
    chk("err", o_err, stray_done);
    chk("busy_end", o_busy, 0);
    step();
    chk("dones", dones, 1);
  endtask

  task automatic reset_mid_fill();
    int t = 0;
    start_job(1, 0);
    i_row_valid = 1'b1;
    while (wr_cnt < 30 && t < 200) begin
      step();
      t++;
    end
    chk("fill_reached", wr_cnt, 30);
    i_rst_n = 1'b0;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_we", o_buf_we, 0);
    chk("rst_waddr", o_buf_waddr, 0);
    chk("rst_start", o_q_start, 0);
    chk("rst_done", o_done, 0);
    chk("rst_tiles", o_tile_cnt, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rready", o_row_ready, 0);
    i_row_valid = 1'b0;
    step();
    i_rst_n = 1'b1;
    wr_cnt = 0;
    pend = 0;
    step();
    chk("rdy_after_rst", o_cfg_ready, 1);
  endtask

  initial begin
    step();
    step();
    chk("r_ready", o_cfg_ready, 1);
    chk("r_busy", o_busy, 0);
    chk("r_tiles", o_tile_cnt, 0);
    chk("r_err", o_err, 0);
    chk("r_start", o_q_start, 0);
    chk("r_done", o_done, 0);
    i_rst_n = 1'b1;
    step();
    chk("r_ready_rel", o_cfg_ready, 1);

    run_job(1, 0, 1'b0, 1'b0);
    run_job(3, 1, 1'b0, 1'b0);
    run_job(0, 2, 1'b0, 1'b0);
    run_job(2, 2, 1'b1, 1'b0);
    run_job(2, 2, 1'b0, 1'b1);
    reset_mid_fill();
    run_job(1, 0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 4), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_job(255, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
